uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame; legal range 5..8.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of clock.
REQ-004 uartClock  input  1  oversample tick at 16x baud, one clock period wide; the block SHALL count ticks only on clock edges where uartClock=1.
REQ-005 RxD  input  1  asynchronous serial line; idle high; 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1).
REQ-006 RxData  output  8  last correctly framed byte; bits above DATA_BITS-1 read 0.
REQ-007 RxReady  output  1  one-clock pulse when RxData is updated.
REQ-008 FramingError  output  1  one-clock pulse when the stop bit samples 0.
REQ-009 Busy  output  1  high in any state other than IDLE.

Function
REQ-010 RxD SHALL pass through a 2-flop synchronizer, reset value 1; all sampling uses the synchronized value rxs.
REQ-011 States SHALL be IDLE, START, DATA, STOP and BREAK, with a 4-bit tick counter and a 3-bit bit counter.
REQ-012 IDLE: on a tick with rxs=0, go to START and clear the tick counter; otherwise remain in IDLE.
REQ-013 START: increment the tick counter on each tick. At the tick where the count reaches 7 (mid start bit), go to DATA and clear both counters if rxs=0; if rxs=1 (glitch), return to IDLE.
REQ-014 DATA: at each tick where the tick counter reaches 15, shift rxs into the shift register MSB-first-in, so that the LSB arrives first, wrap the tick counter to 0, and increment the bit counter.
REQ-015 DATA: when bit DATA_BITS-1 is sampled, go to STOP.
REQ-016 STOP: at tick count 15 with rxs=1, load RxData (right-justified), pulse RxReady on the next clock edge, and go to IDLE.
REQ-017 STOP: at tick count 15 with rxs=0, pulse FramingError, leave RxData unchanged, and go to BREAK.
REQ-018 BREAK: remain until a tick with rxs=1, then go to IDLE; no new start is detected while in BREAK.
REQ-019 Latency: RxReady and FramingError SHALL assert exactly one clock after the clock edge of the stop-bit sampling tick, and deassert after one clock.
REQ-020 RxData SHALL hold its value until the next valid frame; there is no overrun flag, so an unread byte is silently overwritten.
REQ-021 If RxReady and a new start are detected on the same tick, the new start SHALL be accepted; the IDLE-to-START transition is unaffected by output pulses.
REQ-022 rxs changes between ticks SHALL have no effect; only tick-edge samples matter.
REQ-023 The counters SHALL wrap modulo 16 (tick) and modulo 8 (bit), with no overflow beyond these widths.

Reset
REQ-024 Reset=0 SHALL set: state=IDLE, counters=0, shift register=0, RxData=0, RxReady=0, FramingError=0, Busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame: no RxReady and no FramingError are produced, and reception restarts only on a fresh start edge after Reset=1.
REQ-026 Reset deassertion SHALL be synchronized to clock internally, with release taking effect on a clock edge.

Verification
REQ-027 Frame 0x55 (DATA_BITS=8) at 16 ticks/bit, tick every 4 clocks -> one RxReady pulse, RxData=0x55, FramingError=0, Busy=0 afterwards.
REQ-028 Frames 0xA3 then 0x0F back-to-back, with no idle between stop and next start -> two RxReady pulses; RxData=0xA3 then 0x0F.
REQ-029 RxD low for 4 ticks, then high -> return to IDLE after the tick-7 sample; no RxReady, no FramingError.
REQ-030 Frame 0x3C with stop bit 0, RxD held low for 40 ticks, then high -> one FramingError pulse; RxData keeps its previous value; Busy high until the first tick with RxD=1.
REQ-031 Reset pulsed low during data bit 3 of frame 0x81, then frame 0x42 sent -> no output for 0x81; RxData=0x42 with a single RxReady.
REQ-032 DATA_BITS=5, frame 0x15 -> RxData=0x15, upper 3 bits 0, RxReady one clock after the stop-bit tick.

Source files
------------

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver with RxD synchronizer, framing-error detection and a break state.
// Reset is asserted asynchronously and released synchronously to clock.
module uart_receiver #(
    parameter int unsigned DATA_BITS = 8
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       uartClock,
    input  logic       RxD,
    output logic [7:0] RxData,
    output logic       RxReady,
    output logic       FramingError,
    output logic       Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_t;

    localparam logic [2:0]  LastBit = 3'(DATA_BITS - 1);
    localparam int unsigned Pad     = 8 - DATA_BITS;

    logic [1:0] r_rst_sync;
    logic       w_rst_n;
    logic       r_rx_meta;
    logic       r_rxs;
    state_t     r_state;
    logic [3:0] r_tick;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_rdy_pend;
    logic       r_fe_pend;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= RxD;
            r_rxs     <= r_rx_meta;
        end
    end

    // Stop-bit outcome is staged one clock so RxReady/FramingError follow the sampling tick edge.
    always_ff @(posedge clock or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= StIdle;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_rdy_pend   <= 1'b0;
            r_fe_pend    <= 1'b0;
            RxData       <= '0;
            RxReady      <= 1'b0;
            FramingError <= 1'b0;
        end else begin
            r_rdy_pend   <= 1'b0;
            r_fe_pend    <= 1'b0;
            RxReady      <= r_rdy_pend;
            FramingError <= r_fe_pend;
            if (r_rdy_pend) begin
                RxData <= r_shift >> Pad;
            end
            if (uartClock) begin
                unique case (r_state)
                    StIdle: begin
                        if (!r_rxs) begin
                            r_state <= StStart;
                            r_tick  <= '0;
                        end
                    end
                    StStart: begin
                        if (r_tick == 4'd7) begin
                            r_tick  <= '0;
                            r_bit   <= '0;
                            r_state <= r_rxs ? StIdle : StData;
                        end else begin
                            r_tick <= r_tick + 4'd1;
                        end
                    end
                    StData: begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == 4'd15) begin
                            // LSB arrives first and ends up at bit 8-DATA_BITS after the last shift.
                            r_shift <= {r_rxs, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                            if (r_bit == LastBit) begin
                                r_state <= StStop;
                            end
                        end
                    end
                    StStop: begin
                        r_tick <= r_tick + 4'd1;
                        if (r_tick == 4'd15) begin
                            if (r_rxs) begin
                                r_rdy_pend <= 1'b1;
                                r_state    <= StIdle;
                            end else begin
                                r_fe_pend <= 1'b1;
                                r_state   <= StBreak;
                            end
                        end
                    end
                    StBreak: begin
                        if (r_rxs) begin
                            r_state <= StIdle;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign Busy = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Testbench for uart_receiver: 8-bit and 5-bit instances driven with directed and random frames,
// checked against a frame-timing model (start seen on the next tick, mid-start 8 ticks later).
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int TicksPerBit = 16;

    logic       clock     = 1'b0;
    logic       Reset     = 1'b1;
    logic       uartClock = 1'b0;
    logic       RxD       = 1'b1;
    logic       RxD5      = 1'b1;
    logic [7:0] RxData;
    logic [7:0] RxData5;
    logic       RxReady;
    logic       RxReady5;
    logic       FramingError;
    logic       FramingError5;
    logic       Busy;
    logic       Busy5;

    typedef struct {
        logic [7:0] data;
        int         tick;
    } ev_t;

    ev_t        rdy_q[$];
    ev_t        rdy5_q[$];
    int         fe_q[$];
    int         fe5_q[$];
    int         tick_idx    = 0;
    int         tests       = 0;
    int         fails       = 0;
    logic [7:0] model_last8 = 8'h00;
    logic [7:0] model_last5 = 8'h00;

    uart_receiver #(.DATA_BITS(8)) u_dut (
        .clock       (clock),
        .Reset       (Reset),
        .uartClock   (uartClock),
        .RxD         (RxD),
        .RxData      (RxData),
        .RxReady     (RxReady),
        .FramingError(FramingError),
        .Busy        (Busy)
    );

    uart_receiver #(.DATA_BITS(5)) u_dut5 (
        .clock       (clock),
        .Reset       (Reset),
        .uartClock   (uartClock),
        .RxD         (RxD5),
        .RxData      (RxData5),
        .RxReady     (RxReady5),
        .FramingError(FramingError5),
        .Busy        (Busy5)
    );

    initial begin : clk_gen
        forever #5 clock = ~clock;
    end

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(negedge clock);
            div = (div + 1) % 4;
            uartClock = (div == 0);
        end
    end

    // Records every output pulse with the index of the tick edge one clock before it.
    initial begin : monitor
        int  edge_tick;
        int  prev_tick;
        ev_t ev;
        prev_tick = -1;
        forever begin
            @(posedge clock);
            if (uartClock === 1'b1) tick_idx++;
            edge_tick = (uartClock === 1'b1) ? tick_idx : -1;
            @(negedge clock);
            if (RxReady === 1'b1) begin
                ev.data = RxData;
                ev.tick = prev_tick;
                rdy_q.push_back(ev);
            end
            if (RxReady5 === 1'b1) begin
                ev.data = RxData5;
                ev.tick = prev_tick;
                rdy5_q.push_back(ev);
            end
            if (FramingError === 1'b1) fe_q.push_back(prev_tick);
            if (FramingError5 === 1'b1) fe5_q.push_back(prev_tick);
            prev_tick = edge_tick;
        end
    end

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            while (uartClock !== 1'b1) @(posedge clock);
        end
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) RxD5 = v;
        else RxD = v;
    endtask

    task automatic clear_queues();
        rdy_q.delete();
        rdy5_q.delete();
        fe_q.delete();
        fe5_q.delete();
    endtask

    // Must be called just after a tick edge; returns just after the last tick of the stop bit.
    task automatic send_frame(input bit sel, input logic [7:0] b, input int nb, input logic stop,
                              output int stop_tick);
        stop_tick = tick_idx + 1 + 8 + TicksPerBit * (nb + 1);
        drive(sel, 1'b0);
        wait_ticks(TicksPerBit);
        for (int i = 0; i < nb; i++) begin
            drive(sel, b[i]);
            wait_ticks(TicksPerBit);
        end
        drive(sel, stop);
        wait_ticks(TicksPerBit);
    endtask

    task automatic test_reset();
        #1 Reset = 1'b0;
        repeat (4) @(negedge clock);
        tests++; if (RxData !== 8'h00) begin fails++; $display("FAIL rst_rxdata: got %0h expected 00", RxData); end
        tests++; if (RxReady !== 1'b0) begin fails++; $display("FAIL rst_rxready: got %b expected 0", RxReady); end
        tests++; if (FramingError !== 1'b0) begin fails++; $display("FAIL rst_fe: got %b expected 0", FramingError); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", Busy); end
        tests++; if (RxData5 !== 8'h00) begin fails++; $display("FAIL rst_rxdata5: got %0h expected 00", RxData5); end
        tests++; if (Busy5 !== 1'b0) begin fails++; $display("FAIL rst_busy5: got %b expected 0", Busy5); end
        Reset = 1'b1;
        model_last8 = 8'h00;
        model_last5 = 8'h00;
        wait_ticks(4);
        @(negedge clock);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rst_busy_release: got %b expected 0", Busy); end
    endtask

    task automatic test_frame_55();
        int st;
        clear_queues();
        wait_ticks(1);
        send_frame(1'b0, 8'h55, 8, 1'b1, st);
        model_last8 = 8'h55;
        wait_ticks(2);
        @(negedge clock);
        tests++;
        if (rdy_q.size() != 1) begin
            fails++; $display("FAIL f55_count: got %0d pulses expected 1", rdy_q.size());
        end else begin
            tests++; if (rdy_q[0].data !== 8'h55) begin fails++; $display("FAIL f55_data: got %0h expected 55", rdy_q[0].data); end
            tests++; if (rdy_q[0].tick != st) begin fails++; $display("FAIL f55_latency: got tick %0d expected %0d", rdy_q[0].tick, st); end
        end
        tests++; if (fe_q.size() != 0) begin fails++; $display("FAIL f55_fe: got %0d pulses expected 0", fe_q.size()); end
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL f55_busy: got %b expected 0", Busy); end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL f55_hold: got %0h expected %0h", RxData, model_last8); end
    endtask

    task automatic test_back_to_back();
        int st1;
        int st2;
        clear_queues();
        wait_ticks(1);
        send_frame(1'b0, 8'hA3, 8, 1'b1, st1);
        send_frame(1'b0, 8'h0F, 8, 1'b1, st2);
        model_last8 = 8'h0F;
        wait_ticks(2);
        @(negedge clock);
        tests++;
        if (rdy_q.size() != 2) begin
            fails++; $display("FAIL b2b_count: got %0d pulses expected 2", rdy_q.size());
        end else begin
            tests++; if (rdy_q[0].data !== 8'hA3 || rdy_q[0].tick != st1) begin
                fails++; $display("FAIL b2b_first: got %0h@%0d expected a3@%0d", rdy_q[0].data, rdy_q[0].tick, st1); end
            tests++; if (rdy_q[1].data !== 8'h0F || rdy_q[1].tick != st2) begin
                fails++; $display("FAIL b2b_second: got %0h@%0d expected 0f@%0d", rdy_q[1].data, rdy_q[1].tick, st2); end
        end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL b2b_rxdata: got %0h expected %0h", RxData, model_last8); end
    endtask

    task automatic test_glitch();
        clear_queues();
        wait_ticks(1);
        drive(1'b0, 1'b0);
        wait_ticks(4);
        drive(1'b0, 1'b1);
        wait_ticks(3);
        @(negedge clock);
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_mid: got %b expected 1", Busy); end
        wait_ticks(12);
        @(negedge clock);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_end: got %b expected 0", Busy); end
        tests++; if (rdy_q.size() != 0) begin fails++; $display("FAIL glitch_rdy: got %0d pulses expected 0", rdy_q.size()); end
        tests++; if (fe_q.size() != 0) begin fails++; $display("FAIL glitch_fe: got %0d pulses expected 0", fe_q.size()); end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL glitch_hold: got %0h expected %0h", RxData, model_last8); end
    endtask

    task automatic test_framing();
        int st;
        clear_queues();
        wait_ticks(1);
        send_frame(1'b0, 8'h3C, 8, 1'b0, st);
        wait_ticks(40 - TicksPerBit);
        @(negedge clock);
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL fe_busy_break: got %b expected 1", Busy); end
        drive(1'b0, 1'b1);
        wait_ticks(1);
        @(negedge clock);
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL fe_busy_release: got %b expected 0", Busy); end
        tests++;
        if (fe_q.size() != 1) begin
            fails++; $display("FAIL fe_count: got %0d pulses expected 1", fe_q.size());
        end else begin
            tests++; if (fe_q[0] != st) begin fails++; $display("FAIL fe_latency: got tick %0d expected %0d", fe_q[0], st); end
        end
        tests++; if (rdy_q.size() != 0) begin fails++; $display("FAIL fe_rdy: got %0d pulses expected 0", rdy_q.size()); end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL fe_hold: got %0h expected %0h", RxData, model_last8); end
    endtask

    task automatic test_reset_midframe();
        int         st;
        logic [7:0] b;
        b = 8'h81;
        clear_queues();
        wait_ticks(1);
        drive(1'b0, 1'b0);
        wait_ticks(TicksPerBit);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, b[i]);
            wait_ticks(TicksPerBit);
        end
        drive(1'b0, b[3]);
        wait_ticks(8);
        @(negedge clock);
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL rmf_busy_before: got %b expected 1", Busy); end
        Reset = 1'b0;
        #1;
        tests++; if (Busy !== 1'b0) begin fails++; $display("FAIL rmf_busy_async: got %b expected 0", Busy); end
        tests++; if (RxData !== 8'h00) begin fails++; $display("FAIL rmf_rxdata_async: got %0h expected 00", RxData); end
        model_last8 = 8'h00;
        model_last5 = 8'h00;
        drive(1'b0, 1'b1);
        repeat (5) @(negedge clock);
        Reset = 1'b1;
        wait_ticks(20);
        send_frame(1'b0, 8'h42, 8, 1'b1, st);
        model_last8 = 8'h42;
        wait_ticks(2);
        @(negedge clock);
        tests++;
        if (rdy_q.size() != 1) begin
            fails++; $display("FAIL rmf_count: got %0d pulses expected 1", rdy_q.size());
        end else begin
            tests++; if (rdy_q[0].data !== 8'h42 || rdy_q[0].tick != st) begin
                fails++; $display("FAIL rmf_frame: got %0h@%0d expected 42@%0d", rdy_q[0].data, rdy_q[0].tick, st); end
        end
        tests++; if (fe_q.size() != 0) begin fails++; $display("FAIL rmf_fe: got %0d pulses expected 0", fe_q.size()); end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL rmf_rxdata: got %0h expected %0h", RxData, model_last8); end
    endtask

    task automatic test_data5();
        int         st;
        logic [7:0] d;
        clear_queues();
        wait_ticks(1);
        send_frame(1'b1, 8'h15, 5, 1'b1, st);
        model_last5 = 8'h15;
        wait_ticks(2);
        @(negedge clock);
        d = RxData5;
        tests++;
        if (rdy5_q.size() != 1) begin
            fails++; $display("FAIL d5_count: got %0d pulses expected 1", rdy5_q.size());
        end else begin
            tests++; if (rdy5_q[0].data !== 8'h15) begin fails++; $display("FAIL d5_data: got %0h expected 15", rdy5_q[0].data); end
            tests++; if (rdy5_q[0].tick != st) begin fails++; $display("FAIL d5_latency: got tick %0d expected %0d", rdy5_q[0].tick, st); end
        end
        tests++; if (d[7:5] !== 3'b000) begin fails++; $display("FAIL d5_upper: got %b expected 000", d[7:5]); end
        tests++; if (fe5_q.size() != 0) begin fails++; $display("FAIL d5_fe: got %0d pulses expected 0", fe5_q.size()); end
        tests++; if (rdy_q.size() != 0) begin fails++; $display("FAIL d5_other_rdy: got %0d pulses expected 0", rdy_q.size()); end
    endtask

    task automatic test_random();
        ev_t        exp_r[$];
        ev_t        exp_r5[$];
        int         exp_f[$];
        int         exp_f5[$];
        ev_t        e;
        bit         sel;
        int         nb;
        int         st;
        int         gap;
        logic [7:0] b;
        logic       stop;
        clear_queues();
        wait_ticks(1);
        for (int n = 0; n < 14; n++) begin
            sel  = ($urandom_range(0, 2) == 0);
            nb   = sel ? 5 : 8;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(sel, b, nb, stop, st);
            if (stop) begin
                e.data = 8'((32'(b)) % (32'd1 << nb));
                e.tick = st;
                if (sel) begin exp_r5.push_back(e); model_last5 = e.data; end
                else begin exp_r.push_back(e); model_last8 = e.data; end
                gap = $urandom_range(0, 3);
            end else begin
                if (sel) exp_f5.push_back(st);
                else exp_f.push_back(st);
                gap = $urandom_range(1, 4);
            end
            drive(sel, 1'b1);
            if (gap > 0) wait_ticks(gap);
        end
        wait_ticks(2);
        @(negedge clock);
        tests++; if (rdy_q.size() != exp_r.size()) begin fails++; $display("FAIL rand_rdy_count: got %0d expected %0d", rdy_q.size(), exp_r.size()); end
        for (int i = 0; i < exp_r.size(); i++) begin
            tests++;
            if (i >= rdy_q.size()) begin
                fails++; $display("FAIL rand_rdy[%0d]: got none expected %0h@%0d", i, exp_r[i].data, exp_r[i].tick);
            end else if (rdy_q[i].data !== exp_r[i].data || rdy_q[i].tick != exp_r[i].tick) begin
                fails++; $display("FAIL rand_rdy[%0d]: got %0h@%0d expected %0h@%0d", i, rdy_q[i].data, rdy_q[i].tick, exp_r[i].data, exp_r[i].tick);
            end
        end
        tests++; if (rdy5_q.size() != exp_r5.size()) begin fails++; $display("FAIL rand_rdy5_count: got %0d expected %0d", rdy5_q.size(), exp_r5.size()); end
        for (int i = 0; i < exp_r5.size(); i++) begin
            tests++;
            if (i >= rdy5_q.size()) begin
                fails++; $display("FAIL rand_rdy5[%0d]: got none expected %0h@%0d", i, exp_r5[i].data, exp_r5[i].tick);
            end else if (rdy5_q[i].data !== exp_r5[i].data || rdy5_q[i].tick != exp_r5[i].tick) begin
                fails++; $display("FAIL rand_rdy5[%0d]: got %0h@%0d expected %0h@%0d", i, rdy5_q[i].data, rdy5_q[i].tick, exp_r5[i].data, exp_r5[i].tick);
            end
        end
        tests++; if (fe_q != exp_f) begin fails++; $display("FAIL rand_fe: got %0d pulses expected %0d (or ticks differ)", fe_q.size(), exp_f.size()); end
        tests++; if (fe5_q != exp_f5) begin fails++; $display("FAIL rand_fe5: got %0d pulses expected %0d (or ticks differ)", fe5_q.size(), exp_f5.size()); end
        tests++; if (RxData !== model_last8) begin fails++; $display("FAIL rand_rxdata: got %0h expected %0h", RxData, model_last8); end
        tests++; if (RxData5 !== model_last5) begin fails++; $display("FAIL rand_rxdata5: got %0h expected %0h", RxData5, model_last5); end
        tests++; if (Busy !== 1'b0 || Busy5 !== 1'b0) begin fails++; $display("FAIL rand_busy: got %b%b expected 00", Busy, Busy5); end
    endtask

    initial begin : main
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_reset_midframe();
        test_data5();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
